// File: rtl/top_servo.sv
// rtl/top_servo.sv - closed-loop PWM position controller for a DC servo
//
// Compares the clamped commanded angle with the measured shaft angle once per
// PWM period and registers a new duty, direction and at-target flag. The drive
// is forced off for any update that sees overcurrent, and the fault is sticky.
// Optional feature macro: INTEGRAL_EN adds an anti-windup integrator (PI control).
//
// Ports:
//   clk             in   system clock, rising edge
//   rst_n           in   synchronous active-low reset
//   grades          in   commanded angle, 0.1 deg units (clamped to ANG_MAX)
//   measure_current in   motor current, mA
//   measure_grades  in   measured shaft angle, 0.1 deg units
//   pwm_out         out  motor PWM, active high, registered
//   dir_out         out  1 = drive toward increasing angle
//   duty            out  applied duty in clk cycles per period
//   at_target       out  |error| <= DEADBAND at the last update
//   oc_fault        out  sticky overcurrent flag
module top_servo #(
  parameter int ANG_W      = 12,
  parameter int CUR_W      = 12,
  parameter int ANG_MAX    = 1800,
  parameter int PWM_PERIOD = 1000,
  parameter int KP         = 4,
  parameter int KP_SHIFT   = 2,
  parameter int DEADBAND   = 5,
  parameter int I_LIMIT    = 2000,
  parameter int KI         = 1,
  parameter int KI_SHIFT   = 6,
  localparam int DW        = $clog2(PWM_PERIOD + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ANG_W-1:0] grades,
  input  logic [CUR_W-1:0] measure_current,
  input  logic [ANG_W-1:0] measure_grades,
  output logic             pwm_out,
  output logic             dir_out,
  output logic [DW-1:0]    duty,
  output logic             at_target,
  output logic             oc_fault
);

  // KP is at most 8 bits wide, so the product fits in ANG_W+8 bits.
  localparam int PW = ANG_W + 8;
  localparam logic [DW-1:0] CNT_LAST = DW'(PWM_PERIOD - 1);
  localparam logic [DW-1:0] DUTY_MAX = DW'(PWM_PERIOD);

  if (KP < 1 || KP > 255 || KI < 1 || KI_SHIFT < 0) begin : g_bad_gain_cfg
    $error("top_servo: gain parameters out of range");
  end

  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] duty_q, duty_d;
  logic          pwm_q, pwm_d;
  logic          dir_q, dir_d;
  logic          at_q, at_d;
  logic          oc_q, oc_d;

  logic                    upd;
  logic [ANG_W-1:0]        cmd;
  logic signed [ANG_W:0]   err;
  logic [ANG_W-1:0]        mag;
  logic [PW-1:0]           p;
  logic                    in_db;
  logic                    oc_now;
  logic [DW-1:0]           duty_new;
  logic                    dir_new;

`ifdef INTEGRAL_EN
  localparam int ACC_W = 32;
  localparam logic signed [ACC_W-1:0] ACC_LIM = ACC_W'((PWM_PERIOD << KI_SHIFT) / KI);
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] acc_sum, acc_next, ki_term, p_s, u, u_mag;
`endif

  assign upd    = (cnt_q == CNT_LAST);
  assign cmd    = (grades > ANG_W'(ANG_MAX)) ? ANG_W'(ANG_MAX) : grades;
  assign err    = $signed({1'b0, cmd}) - $signed({1'b0, measure_grades});
  // |err| never exceeds 2^ANG_W - 1, so dropping the sign bit is lossless.
  assign mag    = err[ANG_W] ? ANG_W'(-err) : err[ANG_W-1:0];
  assign p      = (PW'(mag) * PW'(KP)) >> KP_SHIFT;
  assign in_db  = (mag <= ANG_W'(DEADBAND));
  assign oc_now = (measure_current > CUR_W'(I_LIMIT));

  always_comb begin
    duty_new = '0;
    dir_new  = dir_q;
`ifdef INTEGRAL_EN
    acc_sum = acc_q + ACC_W'(err);
    if (acc_sum > ACC_LIM)
      acc_next = ACC_LIM;
    else if (acc_sum < -ACC_LIM)
      acc_next = -ACC_LIM;
    else
      acc_next = acc_sum;
    if (in_db || oc_now)
      acc_next = '0;
    ki_term = ACC_W'((acc_next * KI) >>> KI_SHIFT);
    p_s     = err[ANG_W] ? -$signed(ACC_W'(p)) : $signed(ACC_W'(p));
    u       = p_s + ki_term;
    u_mag   = u[ACC_W-1] ? -u : u;
    duty_new = (u_mag > ACC_W'(PWM_PERIOD)) ? DUTY_MAX : DW'(u_mag);
    if (u != '0)
      dir_new = ~u[ACC_W-1];
`else
    duty_new = (p > PW'(PWM_PERIOD)) ? DUTY_MAX : DW'(p);
    if (err != '0)
      dir_new = ~err[ANG_W];
`endif
    // Overcurrent and deadband both silence the drive for this period.
    if (in_db || oc_now)
      duty_new = '0;
  end

  // Duty and direction only move on the wrap edge, so each period is clean.
  always_comb begin
    cnt_d  = upd ? '0 : cnt_q + 1'b1;
    duty_d = upd ? duty_new : duty_q;
    dir_d  = upd ? dir_new : dir_q;
    at_d   = upd ? in_db : at_q;
    oc_d   = oc_q | (upd & oc_now);
    // Registered compare against the next count keeps pwm aligned to cnt.
    pwm_d  = (cnt_d < duty_d);
`ifdef INTEGRAL_EN
    acc_d  = upd ? acc_next : acc_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
      dir_q  <= 1'b0;
      at_q   <= 1'b0;
      oc_q   <= 1'b0;
`ifdef INTEGRAL_EN
      acc_q  <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
      dir_q  <= dir_d;
      at_q   <= at_d;
      oc_q   <= oc_d;
`ifdef INTEGRAL_EN
      acc_q  <= acc_d;
`endif
    end
  end

  assign pwm_out   = pwm_q;
  assign dir_out   = dir_q;
  assign duty      = duty_q;
  assign at_target = at_q;
  assign oc_fault  = oc_q;

endmodule

// File: tb/tb_top_servo.sv
// tb/tb_top_servo.sv - self-checking bench for top_servo
module tb_top_servo;

  localparam int PERIOD = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] grades;
  logic [11:0] measure_current;
  logic [11:0] measure_grades;
  logic        pwm_out;
  logic        dir_out;
  logic [9:0]  duty;
  logic        at_target;
  logic        oc_fault;

  int total = 0;
  int bad   = 0;
  int tb_cnt = 0;
  int mdir = 0;
  int moc  = 0;

  typedef struct {
    int g; int m; int c;
    int duty; int dir; int at; int oc;
  } vec_t;
  vec_t tbl[10];

  top_servo dut (
    .clk(clk), .rst_n(rst_n), .grades(grades),
    .measure_current(measure_current), .measure_grades(measure_grades),
    .pwm_out(pwm_out), .dir_out(dir_out), .duty(duty),
    .at_target(at_target), .oc_fault(oc_fault)
  );

  always #5 clk = ~clk;

  // Independent period counter: where the controller is expected to update.
  always @(posedge clk) begin
    if (!rst_n) tb_cnt <= 0;
    else        tb_cnt <= (tb_cnt == PERIOD - 1) ? 0 : tb_cnt + 1;
  end

  initial begin
    #1500us;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Return just after the next control update edge.
  task automatic wait_update();
    int n = 0;
    while (tb_cnt != PERIOD - 1 && n < PERIOD + 50) begin
      @(negedge clk);
      n++;
    end
    chk("update_timeout", (n < PERIOD + 50) ? 1 : 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Count high cycles over one full period; ends at the cnt=PERIOD-1 negedge.
  task automatic check_period(input string name, input int exp_duty, input int exp_dir);
    int hi = 0;
    int dir_bad = 0;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      if (pwm_out) hi++;
      if (int'(dir_out) != exp_dir) dir_bad++;
    end
    chk({name, "_pwm_high"}, hi, exp_duty);
    chk({name, "_dir_stable"}, dir_bad, 0);
    chk({name, "_duty_held"}, int'(duty), exp_duty);
  endtask

  task automatic model(input int g, input int m, input int c,
                       output int ed, output int eat);
    int cmd, err, mag;
    cmd = (g > 1800) ? 1800 : g;
    err = cmd - m;
    mag = (err < 0) ? -err : err;
    if (err > 0) mdir = 1;
    else if (err < 0) mdir = 0;
    eat = (mag <= 5) ? 1 : 0;
    if (c > 2000) moc = 1;
    if (c > 2000 || eat == 1) ed = 0;
    else begin
      ed = (mag * 4) / 4;
      if (ed > PERIOD) ed = PERIOD;
    end
  endtask

  initial begin
    int ed, eat;
    tbl[0] = '{900,  400,  100,  500, 1, 0, 0};
    tbl[1] = '{0,    1800, 100,  1000, 0, 0, 0};
    tbl[2] = '{900,  897,  100,  0,   1, 1, 0};
    tbl[3] = '{900,  894,  100,  6,   1, 0, 0};
    tbl[4] = '{900,  400,  2001, 0,   1, 0, 1};
    tbl[5] = '{900,  400,  100,  500, 1, 0, 1};
    tbl[6] = '{4000, 1800, 100,  0,   1, 1, 1};
    tbl[7] = '{1800, 1806, 100,  6,   0, 0, 1};
    tbl[8] = '{900,  905,  100,  0,   0, 1, 1};
    tbl[9] = '{900,  400,  2000, 500, 1, 0, 1};

    rst_n = 1'b0; grades = '0; measure_current = '0; measure_grades = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pwm",  int'(pwm_out), 0);
    chk("rst_dir",  int'(dir_out), 0);
    chk("rst_duty", int'(duty), 0);
    chk("rst_at",   int'(at_target), 0);
    chk("rst_oc",   int'(oc_fault), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_update();
    chk("first_at",   int'(at_target), 1);
    chk("first_duty", int'(duty), 0);
    chk("first_dir",  int'(dir_out), 0);
    check_period("first", 0, 0);

    for (int i = 0; i < 10; i++) begin
      grades = 12'(tbl[i].g); measure_grades = 12'(tbl[i].m);
      measure_current = 12'(tbl[i].c);
      wait_update();
      chk($sformatf("v%0d_duty", i), int'(duty), tbl[i].duty);
      chk($sformatf("v%0d_dir", i),  int'(dir_out), tbl[i].dir);
      chk($sformatf("v%0d_at", i),   int'(at_target), tbl[i].at);
      chk($sformatf("v%0d_oc", i),   int'(oc_fault), tbl[i].oc);
      check_period($sformatf("v%0d", i), tbl[i].duty, tbl[i].dir);
    end

    // Mid-period reset at cnt=300 while driving duty 500.
    grades = 12'd900; measure_grades = 12'd400; measure_current = 12'd100;
    wait_update();
    while (tb_cnt != 300) @(negedge clk);
    chk("pre_rst_pwm", int'(pwm_out), 1);
    rst_n = 1'b0; grades = 12'd4000; measure_grades = 12'd1800;
    @(posedge clk);
    #1;
    chk("mid_rst_pwm",  int'(pwm_out), 0);
    chk("mid_rst_duty", int'(duty), 0);
    chk("mid_rst_oc",   int'(oc_fault), 0);
    chk("mid_rst_dir",  int'(dir_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (PERIOD - 1) @(posedge clk);
    #1;
    chk("restart_at_early", int'(at_target), 0);
    @(posedge clk);
    #1;
    chk("restart_at_update", int'(at_target), 1);
    chk("clamp_duty", int'(duty), 0);
    chk("clamp_dir",  int'(dir_out), 0);

    mdir = 0; moc = 0;
    for (int i = 0; i < 16; i++) begin
      int g, m, c;
      g = int'($urandom_range(0, 4095));
      m = (i % 3 == 0) ? g + int'($urandom_range(0, 12)) - 6 : int'($urandom_range(0, 1800));
      if (m < 0) m = 0;
      if (m > 4095) m = 4095;
      c = (i % 5 == 4) ? int'($urandom_range(2001, 4095)) : int'($urandom_range(0, 2000));
      grades = 12'(g); measure_grades = 12'(m); measure_current = 12'(c);
      model(g, m, c, ed, eat);
      wait_update();
      chk($sformatf("r%0d_duty", i), int'(duty), ed);
      chk($sformatf("r%0d_dir", i),  int'(dir_out), mdir);
      chk($sformatf("r%0d_at", i),   int'(at_target), eat);
      chk($sformatf("r%0d_oc", i),   int'(oc_fault), moc);
      check_period($sformatf("r%0d", i), ed, mdir);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
